// File: rtl/serial_subtractor_full_sub.sv
// Full subtractor: x - y - bin built from two half subtractors and an OR,
// the same gate-level shape as the full adder it parallels.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .x  (x),
    .y  (y),
    .d  (d1),
    .bo (b1)
  );

  // Second stage: a borrow can only pass through when x == y (d1 == 0).
  half_subtractor u_hs1 (
    .x  (d1),
    .y  (bin),
    .d  (d),
    .bo (b2)
  );

  assign bo = b1 | b2;

endmodule

// File: rtl/serial_subtractor_half_sub.sv
// Half subtractor: one-bit difference and borrow-out of x - y.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per
// cycle, LSB first, and reports the final borrow (set iff a < b).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter must reach WIDTH after the last bit.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 difference bits produced so far; the final bit is
  // merged in directly when the result is published on DONE entry.
  logic [WIDTH-2:0] partial;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             bit_d;
  logic             bit_bo;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  full_subtractor u_fs (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .bin (borrow),
    .d   (bit_d),
    .bo  (bit_bo)
  );

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN for WIDTH cycles, one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/result datapath: capture on accept, shift one bit per RUN cycle,
  // publish diff/bout on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      partial <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= bit_bo;
          cnt    <= cnt + CNT_W'(1);
          if (WIDTH > 2) begin
            partial <= {bit_d, partial[WIDTH-2:1]};
          end else begin
            partial <= bit_d;
          end
          if (last_bit) begin
            diff <= {bit_d, partial};
            bout <= bit_bo;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): a cycle model of the handshake feeds
// a scoreboard of expected results that is drained on every done pulse.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  exp_t         sbq[$];
  int           tests    = 0;
  int           fails    = 0;
  int           m        = 0;  // 0 idle, 1..W run cycle, W+1 done
  int           accepted = 0;
  logic [W-1:0] held_d   = '0;
  logic         held_b   = 1'b0;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] t;
    exp_t       e;
    t    = {1'b0, x} - {1'b0, y};
    e.d  = t[W-1:0];
    e.bo = t[W];
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model over the edge, then compare the DUT.
  task automatic tick();
    logic         r;
    logic         acc;
    logic [W-1:0] ca;
    logic [W-1:0] cb;
    exp_t         e;
    r   = rst;
    acc = !rst && (m == 0) && start;
    ca  = a;
    cb  = b;
    @(posedge clk);
    #2;
    if (r) begin
      m = 0;
      sbq.delete();
      held_d = '0;
      held_b = 1'b0;
    end else if (m == 0) begin
      if (acc) begin
        m = 1;
        sbq.push_back(model(ca, cb));
        accepted++;
      end
    end else if (m == W + 1) begin
      m = 0;
    end else begin
      m++;
    end
    check("busy", 32'(busy), 32'(m != 0));
    check("done", 32'(done), 32'(m == W + 1));
    if (m == W + 1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: done with diff=%0h but no result expected", diff);
      end else begin
        e = sbq.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("bout", 32'(bout), 32'(e.bo));
        held_d = e.d;
        held_b = e.bo;
      end
    end else begin
      check("diff_hold", 32'(diff), 32'(held_d));
      check("bout_hold", 32'(bout), 32'(held_b));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m != 0 && n < 4 * W) begin
      tick();
      n++;
    end
    if (m != 0) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    wait_idle();
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    vec_t tv[6];
    int   n;
    int   base;
    int   bound;

    tv[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
    tv[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
    tv[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    tv[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    tv[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tv[5] = '{8'hC3, 8'h3C, 8'h87, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_diff", 32'(diff), 32'h0);
    check("rst_bout", 32'(bout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // First vector is started on the very first edge after reset release.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_op(tv[i].a, tv[i].b);
      check("vec_diff", 32'(diff), 32'(tv[i].d));
      check("vec_bout", 32'(bout), 32'(tv[i].bo));
    end

    // Starts and operand changes while busy are ignored; a start held through
    // DONE is taken on the first IDLE cycle.
    a     = 8'h3C;
    b     = 8'h5E;
    start = 1'b1;
    tick();
    for (int k = 0; k < W; k++) begin
      a     = W'($urandom_range(0, 255));
      b     = W'($urandom_range(0, 255));
      start = (k % 2 == 0);
      tick();
    end
    check("ign_diff", 32'(diff), 32'hDE);
    check("ign_bout", 32'(bout), 32'h1);
    a     = 8'h01;
    b     = 8'h02;
    start = 1'b1;
    tick();
    check("done_to_idle_busy", 32'(busy), 32'h0);
    tick();
    check("restart_busy", 32'(busy), 32'h1);
    start = 1'b0;
    wait_idle();
    check("restart_diff", 32'(diff), 32'hFF);

    // Reset on RUN cycle 4 aborts with no done pulse and clears outputs.
    a     = 8'h77;
    b     = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_diff", 32'(diff), 32'h0);
    check("abort_bout", 32'(bout), 32'h0);
    repeat (W + 2) tick();
    run_op(8'h80, 8'h01);
    check("post_abort_diff", 32'(diff), 32'h7F);
    check("post_abort_bout", 32'(bout), 32'h0);

    // Back-to-back random operations with start held high.
    base  = accepted;
    n     = 0;
    bound = 1000 * (W + 2) + 50;
    start = 1'b1;
    while (accepted - base < 1000 && n < bound) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      tick();
      n++;
    end
    start = 1'b0;
    check("rand_count", 32'(accepted - base), 32'd1000);
    check("throughput_cycles", 32'(n), 32'(1 + 999 * (W + 2)));
    wait_idle();
    check("sb_left", 32'(sbq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
